// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared types and constants for the OLED power-up sequencer
package oled_pkg;

    typedef enum logic [3:0] {
        IDLE,
        VDD_ON,
        WAIT,
        SEND,
        SEND_WAIT,
        RES_LO,
        RES_HI,
        VBAT_ON,
        DONE
    } state_t;

    localparam int CMD_COUNT = 10;
    localparam int IDX_W     = 4;

    localparam logic [7:0] CMD_TABLE [CMD_COUNT] = '{
        8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1,
        8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF
    };

    // Index value reached after the last byte of each command burst
    localparam logic [IDX_W-1:0] BURST1_END = 4'd1;
    localparam logic [IDX_W-1:0] BURST2_END = 4'd5;
    localparam logic [IDX_W-1:0] BURST3_END = 4'd10;

endpackage

// File: rtl/oled_cmd_rom.sv
// rtl/oled_cmd_rom.sv - combinational index to command byte lookup
module oled_cmd_rom
    import oled_pkg::*;
(
    input  logic [IDX_W-1:0] index,
    output logic [7:0]       data
);

    always_comb begin
        data = 8'h00;
        if (index < IDX_W'(CMD_COUNT)) begin
            data = CMD_TABLE[index];
        end
    end

endmodule

// File: rtl/oled_init_seq.sv
// rtl/oled_init_seq.sv - OLED rail, reset and command-stream power-up sequencer
module oled_init_seq
    import oled_pkg::*;
#(
    parameter int VBAT_WAIT_UNITS = 50,
    parameter int VDD_WAIT_UNITS  = 1,
    parameter int RES_WAIT_UNITS  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       delayEn,
    input  logic       delayDone,
    output logic [7:0] spiData,
    output logic       spiLoad,
    input  logic       spiDone,
    output logic       oledVdd,
    output logic       oledVbat,
    output logic       oledRes,
    output logic       oledDc,
    output logic       busy,
    output logic       initDone
);

    localparam int CNT_W = 16;

    // Counter holds remaining units minus one, so it loads N-1
    localparam logic [CNT_W-1:0] VDD_LOAD  = CNT_W'(VDD_WAIT_UNITS - 1);
    localparam logic [CNT_W-1:0] RES_LOAD  = CNT_W'(RES_WAIT_UNITS - 1);
    localparam logic [CNT_W-1:0] VBAT_LOAD = CNT_W'(VBAT_WAIT_UNITS - 1);

    state_t             state, state_n;
    state_t             ret_state, ret_state_n;
    logic [CNT_W-1:0]   unit_cnt, unit_cnt_n;
    logic [IDX_W-1:0]   cmd_idx, cmd_idx_n, cmd_idx_inc;
    logic [7:0]         rom_data;

    logic               delayEn_n;
    logic [7:0]         spiData_n;
    logic               spiLoad_n;
    logic               oledVdd_n;
    logic               oledVbat_n;
    logic               oledRes_n;
    logic               busy_n;
    logic               initDone_n;

    logic               unit_tick;

    assign cmd_idx_inc = cmd_idx + IDX_W'(1);
    assign unit_tick   = delayEn && delayDone;

    oled_cmd_rom u_rom (
        .index (cmd_idx),
        .data  (rom_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ret_state <= IDLE;
            unit_cnt  <= '0;
            cmd_idx   <= '0;
            delayEn   <= 1'b0;
            spiData   <= 8'h00;
            spiLoad   <= 1'b0;
            oledVdd   <= 1'b1;
            oledVbat  <= 1'b1;
            oledRes   <= 1'b1;
            oledDc    <= 1'b0;
            busy      <= 1'b0;
            initDone  <= 1'b0;
        end else begin
            state     <= state_n;
            ret_state <= ret_state_n;
            unit_cnt  <= unit_cnt_n;
            cmd_idx   <= cmd_idx_n;
            delayEn   <= delayEn_n;
            spiData   <= spiData_n;
            spiLoad   <= spiLoad_n;
            oledVdd   <= oledVdd_n;
            oledVbat  <= oledVbat_n;
            oledRes   <= oledRes_n;
            oledDc    <= 1'b0;
            busy      <= busy_n;
            initDone  <= initDone_n;
        end
    end

    always_comb begin
        state_n     = state;
        ret_state_n = ret_state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = VDD_ON;
                end
            end
            VDD_ON: begin
                state_n     = WAIT;
                ret_state_n = SEND;
            end
            RES_LO: begin
                state_n     = WAIT;
                ret_state_n = RES_HI;
            end
            RES_HI: begin
                state_n     = WAIT;
                ret_state_n = SEND;
            end
            VBAT_ON: begin
                state_n     = WAIT;
                ret_state_n = SEND;
            end
            WAIT: begin
                if (unit_tick && unit_cnt == '0) begin
                    state_n = ret_state;
                end
            end
            SEND: begin
                state_n = SEND_WAIT;
            end
            SEND_WAIT: begin
                // The index after the increment decides where the burst goes next
                if (spiDone) begin
                    if (cmd_idx_inc == BURST1_END) begin
                        state_n = RES_LO;
                    end else if (cmd_idx_inc == BURST2_END) begin
                        state_n = VBAT_ON;
                    end else if (cmd_idx_inc == BURST3_END) begin
                        state_n = DONE;
                    end else begin
                        state_n = SEND;
                    end
                end
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        unit_cnt_n = unit_cnt;
        cmd_idx_n  = cmd_idx;
        delayEn_n  = delayEn;
        spiData_n  = spiData;
        spiLoad_n  = 1'b0;
        oledVdd_n  = oledVdd;
        oledVbat_n = oledVbat;
        oledRes_n  = oledRes;
        busy_n     = busy;
        initDone_n = initDone;
        case (state)
            IDLE: begin
                if (start) begin
                    busy_n = 1'b1;
                end
            end
            VDD_ON: begin
                oledVdd_n  = 1'b0;
                delayEn_n  = 1'b1;
                unit_cnt_n = VDD_LOAD;
            end
            RES_LO: begin
                oledRes_n  = 1'b0;
                delayEn_n  = 1'b1;
                unit_cnt_n = RES_LOAD;
            end
            RES_HI: begin
                oledRes_n  = 1'b1;
                delayEn_n  = 1'b1;
                unit_cnt_n = RES_LOAD;
            end
            VBAT_ON: begin
                oledVbat_n = 1'b0;
                delayEn_n  = 1'b1;
                unit_cnt_n = VBAT_LOAD;
            end
            WAIT: begin
                // delayEn stays high across units so the generator free-runs
                if (unit_tick) begin
                    if (unit_cnt == '0) begin
                        delayEn_n = 1'b0;
                    end else begin
                        unit_cnt_n = unit_cnt - CNT_W'(1);
                    end
                end
            end
            SEND: begin
                spiLoad_n = 1'b1;
                spiData_n = rom_data;
            end
            SEND_WAIT: begin
                if (spiDone) begin
                    cmd_idx_n = cmd_idx_inc;
                    if (cmd_idx_inc == BURST3_END) begin
                        initDone_n = 1'b1;
                        busy_n     = 1'b0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_oled_init_seq.sv
// tb/tb_oled_init_seq.sv - randomized self-checking bench for oled_init_seq
module tb_oled_init_seq;

    logic       clock;
    logic       reset;
    logic       start;
    logic       delayEn;
    logic       delayDone;
    logic [7:0] spiData;
    logic       spiLoad;
    logic       spiDone;
    logic       oledVdd;
    logic       oledVbat;
    logic       oledRes;
    logic       oledDc;
    logic       busy;
    logic       initDone;

    oled_init_seq dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .delayEn   (delayEn),
        .delayDone (delayDone),
        .spiData   (spiData),
        .spiLoad   (spiLoad),
        .spiDone   (spiDone),
        .oledVdd   (oledVdd),
        .oledVbat  (oledVbat),
        .oledRes   (oledRes),
        .oledDc    (oledDc),
        .busy      (busy),
        .initDone  (initDone)
    );

    localparam logic [7:0] EXP_BYTES [10] = '{
        8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF
    };
    // Delay units that must elapse between the previous transfer and each load
    localparam int REQ_UNITS [10] = '{1, 2, 0, 0, 0, 50, 0, 0, 0, 0};

    int n_chk  = 0;
    int n_pass = 0;

    bit started, fin, fin_pend, outstanding, rst_pend, prev_load, res_low_seen;
    int since_start, loads, dones, seg_units, total_units;
    logic [7:0] cur_byte, first_byte, last_byte;
    bit stray_en, rand_start_en;
    int dcnt, pend;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Delay generator responder: one unit every 20 enabled cycles
    initial begin
        delayDone = 1'b0;
        dcnt = 0;
        forever begin
            step();
            delayDone = 1'b0;
            if (delayEn) begin
                dcnt++;
                if (dcnt == 20) begin
                    delayDone = 1'b1;
                    dcnt = 0;
                end
            end else begin
                dcnt = 0;
                if (stray_en && $urandom_range(0, 3) == 0) delayDone = 1'b1;
            end
        end
    end

    // SPI responder: done 16 cycles after each load, strays only during waits
    initial begin
        spiDone = 1'b0;
        pend = 0;
        forever begin
            step();
            spiDone = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) spiDone = 1'b1;
            end
            if (spiLoad) pend = 16;
            if (stray_en && pend == 0 && delayEn && $urandom_range(0, 7) == 0) spiDone = 1'b1;
        end
    end

    // Model and compare process: outputs checked each cycle, inputs folded in afterwards
    initial begin
        rst_pend = 1'b1;
        forever begin
            @(negedge clock);
            if (rst_pend) begin
                chk("rst_delayEn", delayEn, 0);
                chk("rst_spiLoad", spiLoad, 0);
                chk("rst_spiData", spiData, 0);
                chk("rst_vdd", oledVdd, 1);
                chk("rst_vbat", oledVbat, 1);
                chk("rst_res", oledRes, 1);
                chk("rst_dc", oledDc, 0);
                chk("rst_busy", busy, 0);
                chk("rst_initDone", initDone, 0);
                started = 0; fin = 0; fin_pend = 0; outstanding = 0;
                loads = 0; dones = 0; seg_units = 0; total_units = 0;
                since_start = 0; res_low_seen = 0;
                rst_pend = 0;
            end else begin
                if (fin_pend) begin
                    fin = 1;
                    fin_pend = 0;
                end
                chk("dc_zero", oledDc, 0);
                if (!started) begin
                    chk("idle_busy", busy, 0);
                    chk("idle_initDone", initDone, 0);
                    chk("idle_spiLoad", spiLoad, 0);
                    chk("idle_delayEn", delayEn, 0);
                    chk("idle_vdd", oledVdd, 1);
                    chk("idle_vbat", oledVbat, 1);
                    chk("idle_res", oledRes, 1);
                    chk("idle_spiData", spiData, 0);
                end else begin
                    since_start++;
                    if (since_start == 1) begin
                        chk("start_busy", busy, 1);
                        chk("start_delayEn_early", delayEn, 0);
                    end
                    if (since_start == 2) begin
                        chk("start_vdd", oledVdd, 0);
                        chk("start_delayEn", delayEn, 1);
                    end
                    if (fin) begin
                        chk("done_initDone", initDone, 1);
                        chk("done_busy", busy, 0);
                        chk("done_spiLoad", spiLoad, 0);
                        chk("done_delayEn", delayEn, 0);
                    end else begin
                        chk("run_initDone", initDone, 0);
                        chk("run_busy", busy, 1);
                    end
                    if (spiLoad) begin
                        chk("load_width", prev_load, 0);
                        chk("load_overlap", outstanding, 0);
                        if (loads < 10) begin
                            chk("load_byte", spiData, EXP_BYTES[loads]);
                            chk("units_before_load", seg_units, REQ_UNITS[loads]);
                            chk("load_vbat", oledVbat, (loads >= 5) ? 0 : 1);
                            chk("load_vdd", oledVdd, 0);
                            chk("load_res", oledRes, 1);
                            if (loads >= 1) chk("res_pulse_seen", res_low_seen, 1);
                        end else begin
                            chk("extra_load", spiLoad, 0);
                        end
                        if (loads == 0) first_byte = spiData;
                        last_byte = spiData;
                        outstanding = 1;
                        cur_byte = spiData;
                        loads++;
                    end else if (outstanding) begin
                        chk("data_stable", spiData, cur_byte);
                    end
                    if (delayEn) begin
                        chk("wait_vdd", oledVdd, 0);
                        chk("wait_vs_xfer", outstanding, 0);
                    end
                    if (!oledRes) begin
                        res_low_seen = 1;
                        chk("res_low_window",
                            (dones == 1 && (seg_units == 0 || (seg_units == 1 && !delayEn))) ? 1 : 0, 1);
                    end
                    if (!oledVbat) chk("vbat_early", (dones >= 5) ? 1 : 0, 1);
                end
            end
            prev_load = spiLoad;
            if (reset) begin
                rst_pend = 1;
            end else begin
                if (start && !started) begin
                    started = 1;
                    since_start = 0;
                end
                if (delayDone && delayEn && started) begin
                    if (dones == 0) chk("vdd_unit", oledVdd, 0);
                    if (dones == 1) chk("res_unit", oledRes, (seg_units == 0) ? 0 : 1);
                    if (dones == 5) chk("vbat_unit", oledVbat, 0);
                    seg_units++;
                    total_units++;
                end
                if (spiDone && outstanding) begin
                    outstanding = 0;
                    dones++;
                    seg_units = 0;
                    if (dones == 10) fin_pend = 1;
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_fin(input int budget);
        int c;
        bit vbat_poked;
        c = 0;
        vbat_poked = 0;
        while (!fin && c < budget) begin
            start = (rand_start_en && started && $urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
            if (!vbat_poked && started && dones == 5 && delayEn) begin
                start = 1'b1;
                vbat_poked = 1;
            end
            step();
            c++;
        end
        start = 1'b0;
        chk("run_timeout", fin, 1);
    endtask

    task automatic check_run(input string tag);
        chk({tag, "_loads"}, loads, 10);
        chk({tag, "_units"}, total_units, 53);
        chk({tag, "_first"}, first_byte, 8'hAE);
        chk({tag, "_last"}, last_byte, 8'hAF);
    endtask

    initial begin
        int c;
        reset = 1'b1;
        start = 1'b0;
        stray_en = 1'b0;
        rand_start_en = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        stray_en = 1'b1;
        repeat (20) step();
        rand_start_en = 1'b1;
        pulse_start();
        wait_fin(4000);
        for (int i = 0; i < 12; i++) begin
            start = (i % 3 == 0) ? 1'b1 : 1'b0;
            step();
        end
        start = 1'b0;
        chk("done_hold_initDone", initDone, 1);
        check_run("run1");

        rand_start_en = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (5) step();
        pulse_start();
        c = 0;
        while (!(loads == 3 && outstanding) && c < 2000) begin
            step();
            c++;
        end
        chk("reach_third_send", (loads == 3 && outstanding) ? 1 : 0, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_vdd", oledVdd, 1);
        chk("mid_rst_vbat", oledVbat, 1);
        chk("mid_rst_res", oledRes, 1);
        chk("mid_rst_delayEn", delayEn, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (30) step();

        rand_start_en = 1'b1;
        pulse_start();
        wait_fin(4000);
        repeat (5) step();
        check_run("run3");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
